// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg: helpers shared by fir_filter and fir_decim_out
// Revision: 1.0
// ============================================================================
package fir_pkg;

  localparam int SAT_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] value;
  } sat_res_t;

  function automatic int width_y(input int width_x, input int width_b, input int n);
    return width_x + width_b + n + 1;
  endfunction

  // Round half up by 2**shift, then clip to a signed width_out range.
  function automatic sat_res_t sat_round(input logic signed [SAT_W-1:0] value,
                                         input int shift, input int width_out);
    logic signed [SAT_W-1:0] half;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t res;
    half = 64'sd1 <<< (shift - 1);
    r    = (value + half) >>> shift;
    hi   = (64'sd1 <<< (width_out - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (width_out - 1));
    res.sat = (r > hi) || (r < lo);
    if (r > hi) begin
      res.value = hi;
    end else if (r < lo) begin
      res.value = lo;
    end else begin
      res.value = r;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo: registered FIFO, pop-and-push allowed while full
// Revision: 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d = rd_en ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_decim_out.sv
`default_nettype none
// ============================================================================
// fir_decim_out: decimate, requantize and buffer the fir_filter output stream
// Revision: 1.0
// ============================================================================
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int WIDTH_IN  = width_y(4, 4, 3),
  parameter int WIDTH_OUT = 8,
  parameter int SHIFT     = 2,
  parameter int DECIM     = 2,
  parameter int PHASE     = 0,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        y_valid,
  input  logic signed [WIDTH_IN-1:0]  y,
  output logic signed [WIDTH_OUT-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  input  logic                        clear,
  output logic                        overflow,
  output logic                        saturated
);
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        stg_vld_q, stg_vld_d;
  logic signed [WIDTH_OUT-1:0] stg_data_q, stg_data_d;
  logic                        ovf_q, ovf_d;
  logic                        sat_q, sat_d;
  logic                        keep;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic signed [WIDTH_OUT-1:0] head;
  sat_res_t                    rq;
  logic                        rq_unused;

  always_comb begin
    rq         = sat_round(SAT_W'(y), SHIFT, WIDTH_OUT);
    rq_unused  = ^rq.value[SAT_W-1:WIDTH_OUT];
    keep       = y_valid && (cnt_q == CNT_W'(PHASE));
    cnt_d      = cnt_q;
    if (y_valid) begin
      cnt_d = (cnt_q == CNT_W'(DECIM - 1)) ? '0 : cnt_q + 1'b1;
    end
    stg_vld_d  = keep;
    stg_data_d = keep ? rq.value[WIDTH_OUT-1:0] : stg_data_q;
    pop        = m_valid && m_ready;
    // A set event in the same cycle as clear leaves the flag set.
    sat_d      = (sat_q && !clear) || (keep && rq.sat);
    ovf_d      = (ovf_q && !clear) || (stg_vld_q && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      ovf_q      <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      ovf_q      <= ovf_d;
      sat_q      <= sat_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH_OUT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (stg_vld_q),
    .data_i  (stg_data_q),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign m_valid   = !empty;
  assign m_data    = m_valid ? head : '0;
  assign overflow  = ovf_q;
  assign saturated = sat_q;

endmodule
`default_nettype wire
